apb4_master_ctrl: RTL and testbench
===================================

// Module: apb4_master_ctrl
// PURPOSE
//  APB4 master engine for the AXI4-Lite-to-APB bridge. Accepts one command at a time from the
//  request FIFO and decodes the target among NUM_SLV slaves. Runs the SETUP/ACCESS sequence with
//  PSTRB/PPROT and a PREADY timeout, then returns read data and PSLVERR on a valid/ready response port.
// PARAMETERS
//  ADDR_W      32   APB address width
//  DATA_W      32   APB data width; multiple of 8
//  NUM_SLV     4    number of APB slaves (PSEL lines), 1..16
//  TIMEOUT_CYC 256  max ACCESS cycles awaiting PREADY; 0 = timeout disabled
// PORTS
//  pclk        in   1              APB clock
//  presetn     in   1              reset, asynchronous, active-low
//  cmd_valid   in   1              request available (FIFO not empty)
//  cmd_ready   out  1              1-cycle pop pulse; command captured this cycle
//  cmd_addr    in   ADDR_W         target address
//  cmd_wdata   in   DATA_W         write data
//  cmd_wstrb   in   DATA_W/8       write byte strobes
//  cmd_write   in   1              1=write, 0=read
//  cmd_prot    in   3              protection attributes -> PPROT
//  rsp_valid   out  1              response available
//  rsp_ready   in   1              response consumed
//  rsp_rdata   out  DATA_W         read data; 0 for writes and errors
//  rsp_err     out  1              PSLVERR, decode error or timeout
//  rsp_write   out  1              echo of cmd_write
//  PADDR/PWDATA out ADDR_W/DATA_W  APB address / write data
//  PWRITE      out  1              APB direction
//  PSTRB/PPROT out  DATA_W/8 / 3   APB strobes / protection
//  PSEL        out  NUM_SLV        one-hot slave select
//  PENABLE     out  1              APB access phase
//  PRDATA      in   NUM_SLV*DATA_W per-slave read data; slave i at [i*DATA_W +: DATA_W]
//  PREADY      in   NUM_SLV        per-slave ready
//  PSLVERR     in   NUM_SLV        per-slave error
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. Asserting presetn mid-transfer drops PSEL/PENABLE immediately
//    and discards the pending response.
//  - cmd_ready = 1 only in IDLE with cmd_valid, or in RESP with rsp_ready and cmd_valid.
//    Never asserted otherwise.
//  - On cmd_ready, addr/wdata/wstrb/write/prot are captured into registers.
//  - APB outputs depend only on the state and captured registers. No combinational cmd_* -> APB path.
//  - Slave index = captured addr[ADDR_W-1 -: SW], where SW = $clog2(NUM_SLV) (SW=0 -> slave 0).
//  - Index >= NUM_SLV is a decode error: no PSEL; go SETUP -> RESP with rsp_err=1.
//  - States:
//    - IDLE: cmd_valid -> SETUP.
//    - SETUP: PSEL[idx]=1, PENABLE=0 -> ACCESS.
//    - ACCESS: PSEL[idx]=1, PENABLE=1. PREADY[idx] -> RESP; latch PRDATA slice and PSLVERR[idx].
//      Otherwise wait and count.
//    - RESP: rsp_valid=1, PSEL=0. rsp_ready and cmd_valid -> SETUP (back-to-back).
//      rsp_ready only -> IDLE. Otherwise hold.
//  - Minimum latency: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 if PREADY at N+2.
//  - Reads drive PSTRB=0 and PWDATA=0. Writes return rsp_rdata=0.
//  - APB signals are stable from SETUP until ACCESS completes, and held through wait states.
//  - Timeout: counter clears on entering ACCESS. If it reaches TIMEOUT_CYC-1 with no PREADY:
//    go RESP with rsp_err=1 and rdata=0. The slave is abandoned.
//  - Responses hold stable while rsp_valid=1 and rsp_ready=0.
// STRUCTURE
//  - Shared package apb_bridge_pkg: state_t {IDLE,SETUP,ACCESS,RESP}; apb_cmd_t and apb_rsp_t structs;
//    PPROT bit constants.
//  - Sub-module apb_addr_decoder (combinational): addr -> one-hot sel, idx, dec_err.
// TESTING
//  - Write 0x0000_0010 / 0xDEAD_BEEF / strb 0xF to slave 0, PREADY=1 immediately:
//    PSEL=0001 for 2 cycles, rsp_valid at N+3, rsp_err=0.
//  - Read 0x4000_0004 (slave 1), PREADY low 3 cycles, PRDATA=0x1234_5678:
//    PSEL/PENABLE/PADDR held, rsp_rdata=0x1234_5678, PSTRB=0.
//  - Two queued commands with rsp_ready=1: second SETUP directly after RESP; no IDLE cycle.
//  - PSLVERR=1 with PREADY on a slave-2 read -> rsp_err=1.
//    Address 0xC000_0000 with NUM_SLV=3 -> no PSEL, rsp_err=1.
//  - TIMEOUT_CYC=8 and PREADY stuck low -> PSEL drops after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0.
//  - presetn low during ACCESS -> all outputs 0 at once; after release, the next command starts from IDLE.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: types and constants shared across the AXI4-Lite-to-APB bridge
package apb_bridge_pkg;

    localparam int BR_ADDR_W = 32;
    localparam int BR_DATA_W = 32;

    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [BR_ADDR_W-1:0]   addr;
        logic [BR_DATA_W-1:0]   wdata;
        logic [BR_DATA_W/8-1:0] wstrb;
        logic                   write;
        logic [2:0]             prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [BR_DATA_W-1:0] rdata;
        logic                 err;
        logic                 write;
    } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: top address bits -> slave index, one-hot select and decode error
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic [3:0]         o_idx,
    output logic               o_dec_err
);

    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 0;

    // A shift by the full width yields slave 0 when there is only one slave
    assign o_idx     = 4'(i_addr >> (ADDR_W - SW));
    assign o_dec_err = {28'd0, o_idx} >= 32'(NUM_SLV);
    assign o_sel     = o_dec_err ? '0 : NUM_SLV'(1) << o_idx;

endmodule

// File: rtl/apb4_master_ctrl.sv
// apb4_master_ctrl: single-outstanding APB4 master with slave decode, PREADY timeout and response port
module apb4_master_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_wstrb,
    input  logic                      cmd_write,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_write,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [2:0]                PPROT,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata, w_prdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_write, r_err;
    logic [2:0]          r_prot;
    logic [CW-1:0]       r_cnt;
    logic [NUM_SLV-1:0]  w_sel;
    logic [3:0]          w_idx;
    logic                w_dec_err, w_ready, w_slverr, w_timeout;

    apb_addr_decoder #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
        .i_addr    (r_addr),
        .o_sel     (w_sel),
        .o_idx     (w_idx),
        .o_dec_err (w_dec_err)
    );

    // Pick the addressed slave's read data slice
    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (w_idx == 4'(i)) w_prdata = PRDATA[i*DATA_W +: DATA_W];
    end

    assign w_ready   = |(PREADY & w_sel);
    assign w_slverr  = |(PSLVERR & w_sel);
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TIMEOUT_CYC - 1));

    assign PADDR     = r_addr;
    assign PWDATA    = r_wdata;
    assign PWRITE    = r_write;
    assign PSTRB     = r_wstrb;
    assign PPROT     = r_prot;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign rsp_write = r_write;

    // Transfer state register
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) r_state <= IDLE;
        else          r_state <= w_next;

    // Next state plus handshake and APB phase outputs
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = cmd_valid;
                if (cmd_valid) w_next = SETUP;
            end
            SETUP: begin
                PSEL   = w_sel;
                w_next = w_dec_err ? RESP : ACCESS;
            end
            ACCESS: begin
                PSEL    = w_sel;
                PENABLE = 1'b1;
                if (w_ready || w_timeout) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                cmd_ready = rsp_ready && cmd_valid;
                if (rsp_ready) w_next = cmd_valid ? SETUP : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the command; reads carry zero data and strobes onto the bus
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_write <= 1'b0;
            r_prot  <= '0;
        end else if (cmd_ready) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_write ? cmd_wdata : '0;
            r_wstrb <= cmd_write ? cmd_wstrb : '0;
            r_write <= cmd_write;
            r_prot  <= cmd_prot;
        end

    // Latch the response: slave data on PREADY, forced error on decode miss or timeout
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == SETUP && w_dec_err) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end else if (r_state == ACCESS && w_ready) begin
            r_rdata <= (r_write || w_slverr) ? '0 : w_prdata;
            r_err   <= w_slverr;
        end else if (r_state == ACCESS && w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end

    // Count ACCESS cycles; cleared whenever not in ACCESS so it restarts on entry
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) r_cnt <= '0;
        else          r_cnt <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;

endmodule

// File: tb/tb_apb4_master_ctrl.sv
// tb_apb4_master_ctrl: transaction-timeline model checked every cycle, directed cases plus random traffic
module tb_apb4_master_ctrl;
    import apb_bridge_pkg::*;

    localparam int NS = 3;
    localparam int TO = 8;

    logic           pclk = 1'b0;
    logic           presetn;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [31:0]    cmd_addr, cmd_wdata;
    logic [3:0]     cmd_wstrb;
    logic [2:0]     cmd_prot;
    logic           rsp_valid, rsp_ready, rsp_err, rsp_write;
    logic [31:0]    rsp_rdata, PADDR, PWDATA;
    logic           PWRITE, PENABLE;
    logic [3:0]     PSTRB;
    logic [2:0]     PPROT;
    logic [NS-1:0]  PSEL, PREADY, PSLVERR;
    logic [NS*32-1:0] PRDATA;

    always #5 pclk = ~pclk;

    apb4_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .TIMEOUT_CYC(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .cmd_write(cmd_write), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_write(rsp_write), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB),
        .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wr;
        logic [2:0]  prot;
        int          wait_c;
        logic        slverr;
        logic [31:0] prdata;
        int          gap;
    } txn_t;

    txn_t        q[$];
    txn_t        cur;
    bit          active, clr_valid, rr_mode, obs_got, obs_b2b;
    int          cyc, acc_c, gap_left, n_cmp, n_bad, obs_lat, obs_acc, obs_psel;
    logic [31:0] obs_rdata;
    logic        obs_err;

    function automatic txn_t mk(logic [31:0] a, logic wr, logic [31:0] wd, logic [3:0] st, logic [2:0] pr,
                                int w, logic se, logic [31:0] rd);
        txn_t t;
        t.addr = a; t.wr = wr; t.wdata = wd; t.strb = st; t.prot = pr;
        t.wait_c = w; t.slverr = se; t.prdata = rd; t.gap = 0;
        return t;
    endfunction

    function automatic int idx_of(txn_t t);
        return int'(t.addr[31:30]);
    endfunction

    function automatic bit dec_of(txn_t t);
        return idx_of(t) >= NS;
    endfunction

    // ACCESS cycles: wait states plus the ready cycle, capped by the timeout
    function automatic int nacc_of(txn_t t);
        if (dec_of(t)) return 0;
        return (t.wait_c >= TO) ? TO : t.wait_c + 1;
    endfunction

    function automatic logic err_of(txn_t t);
        return dec_of(t) || t.wait_c >= TO || t.slverr;
    endfunction

    function automatic logic [31:0] rdata_of(txn_t t);
        return (t.wr || err_of(t)) ? 32'd0 : t.prdata;
    endfunction

    function automatic logic [127:0] outs();
        return 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write, PADDR, PWDATA,
                     PWRITE, PSTRB, PPROT, PSEL, PENABLE});
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: compare registered outputs, drive inputs, compare cmd_ready, advance the model
    task automatic cycle();
        int ph, rs, ix, k;
        bit dec, in_acc, in_rsp, done, acc;
        logic [NS-1:0] e_sel;
        logic e_cr;
        @(negedge pclk);
        cyc++;
        ph = 0; rs = 0; ix = 0; dec = 0;
        if (active) begin
            ph = cyc - acc_c;
            ix = idx_of(cur);
            dec = dec_of(cur);
            rs = 2 + nacc_of(cur);
        end
        in_acc = active && ph >= 2 && ph < rs;
        in_rsp = active && ph >= rs;
        e_sel = (active && !dec && ph < rs) ? NS'(1 << ix) : '0;
        chk("psel", 128'(PSEL), 128'(e_sel));
        chk("penable", 128'(PENABLE), 128'(in_acc));
        chk("rsp_valid", 128'(rsp_valid), 128'(in_rsp));
        if (e_sel != 0) begin
            chk("paddr", 128'(PADDR), 128'(cur.addr));
            chk("pwrite", 128'(PWRITE), 128'(cur.wr));
            chk("pwdata", 128'(PWDATA), 128'(cur.wr ? cur.wdata : 32'd0));
            chk("pstrb", 128'(PSTRB), 128'(cur.wr ? cur.strb : 4'd0));
            chk("pprot", 128'(PPROT), 128'(cur.prot));
        end
        if (in_rsp) begin
            chk("rsp_rdata", 128'(rsp_rdata), 128'(rdata_of(cur)));
            chk("rsp_err", 128'(rsp_err), 128'(err_of(cur)));
            chk("rsp_write", 128'(rsp_write), 128'(cur.wr));
        end
        if (active) begin
            if (PENABLE) obs_acc++;
            if (PSEL != 0) obs_psel++;
            if (rsp_valid && !obs_got) begin
                obs_got = 1; obs_lat = ph; obs_rdata = rsp_rdata; obs_err = rsp_err;
            end
        end
        if (clr_valid) begin
            cmd_valid = 1'b0;
            clr_valid = 0;
            gap_left = (q.size() > 0) ? q[0].gap : 0;
        end
        if (!cmd_valid) begin
            cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            cmd_write = 1'($urandom); cmd_prot = 3'($urandom);
            if (q.size() > 0) begin
                if (gap_left > 0) gap_left--;
                else begin
                    cmd_valid = 1'b1;
                    cmd_addr = q[0].addr; cmd_wdata = q[0].wdata; cmd_wstrb = q[0].strb;
                    cmd_write = q[0].wr; cmd_prot = q[0].prot;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            PRDATA[i*32 +: 32] = $urandom;
            PREADY[i] = 1'($urandom);
            PSLVERR[i] = 1'($urandom);
        end
        if (in_acc) begin
            k = ph - 2;
            PREADY[ix] = (k == cur.wait_c);
            if (k == cur.wait_c) begin
                PSLVERR[ix] = cur.slverr;
                PRDATA[ix*32 +: 32] = cur.prdata;
            end
        end
        rsp_ready = rr_mode ? 1'b1 : 1'($urandom);
        #1;
        e_cr = cmd_valid && (!active || (in_rsp && rsp_ready));
        chk("cmd_ready", 128'(cmd_ready), 128'(e_cr));
        done = in_rsp && rsp_ready;
        acc = cmd_valid && e_cr;
        if (done) active = 0;
        if (acc) begin
            cur = q.pop_front();
            active = 1; acc_c = cyc; clr_valid = 1;
            obs_got = 0; obs_lat = 0; obs_acc = 0; obs_psel = 0; obs_rdata = '0; obs_err = 1'b0;
            obs_b2b = done;
        end
    endtask

    task automatic run(int limit);
        int k;
        bit busy;
        k = 0;
        while ((q.size() > 0 || active) && k < limit) begin
            cycle();
            k++;
        end
        busy = q.size() > 0 || active;
        chk("drain_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        txn_t r;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        cmd_write = 1'b0; cmd_prot = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = '0; PSLVERR = '0;
        rr_mode = 0; active = 0; clr_valid = 0; cyc = 0; gap_left = 0; n_cmp = 0; n_bad = 0;
        repeat (3) @(negedge pclk);
        #1 chk("reset_outs", outs(), 128'(0));
        @(negedge pclk) presetn = 1'b1;

        // write to slave 0, immediate PREADY
        q.push_back(mk(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0));
        run(100);
        chk("wr_latency", 128'(obs_lat), 128'(3));
        chk("wr_psel_cycles", 128'(obs_psel), 128'(2));
        chk("wr_err", 128'(obs_err), 128'(0));

        // read from slave 1 with three wait states
        q.push_back(mk(32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'(1 << PPROT_NSEC), 3, 1'b0, 32'h1234_5678));
        run(100);
        chk("rd_rdata", 128'(obs_rdata), 128'(32'h1234_5678));
        chk("rd_access_cycles", 128'(obs_acc), 128'(4));
        chk("rd_latency", 128'(obs_lat), 128'(6));

        // two queued commands, response consumed at once
        rr_mode = 1;
        q.push_back(mk(32'h4000_0020, 1'b0, 32'h0, 4'h0, 3'(1 << PPROT_PRIV), 1, 1'b0, 32'hA5A5_0001));
        q.push_back(mk(32'h8000_0040, 1'b1, 32'h0BAD_F00D, 4'h6, 3'(1 << PPROT_INSTR), 0, 1'b0, 32'h0));
        run(100);
        chk("back_to_back", 128'(obs_b2b), 128'(1));
        rr_mode = 0;

        // slave 2 read with PSLVERR
        q.push_back(mk(32'h8000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b1, 32'hCAFE_F00D));
        run(100);
        chk("slverr_err", 128'(obs_err), 128'(1));
        chk("slverr_rdata", 128'(obs_rdata), 128'(0));

        // decode miss: index 3 with three slaves
        q.push_back(mk(32'hC000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h1111_1111));
        run(100);
        chk("dec_psel_cycles", 128'(obs_psel), 128'(0));
        chk("dec_err", 128'(obs_err), 128'(1));
        chk("dec_latency", 128'(obs_lat), 128'(2));

        // PREADY never arrives
        q.push_back(mk(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 100, 1'b0, 32'h2222_2222));
        run(100);
        chk("to_access_cycles", 128'(obs_acc), 128'(8));
        chk("to_psel_cycles", 128'(obs_psel), 128'(9));
        chk("to_err", 128'(obs_err), 128'(1));
        chk("to_rdata", 128'(obs_rdata), 128'(0));

        // reset asserted during ACCESS
        q.push_back(mk(32'h4000_0008, 1'b1, 32'h0000_55AA, 4'h3, 3'd1, 6, 1'b0, 32'h0));
        repeat (4) cycle();
        chk("pre_rst_penable", 128'(PENABLE), 128'(1));
        #2 presetn = 1'b0;
        cmd_valid = 1'b0;
        #1 chk("mid_rst_outs", outs(), 128'(0));
        active = 0; clr_valid = 0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        q.push_back(mk(32'h0000_0044, 1'b1, 32'h7777_8888, 4'h9, 3'd2, 0, 1'b0, 32'h0));
        run(100);
        chk("post_rst_latency", 128'(obs_lat), 128'(3));

        // random traffic
        for (int t = 0; t < 300; t++) begin
            r = mk($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 3) == 0), $urandom);
            r.gap = int'($urandom_range(0, 2));
            q.push_back(r);
        end
        run(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
